// File: rtl/hash_host_if.sv
// Host-side adapter for the hash cores: packs BUS_W-bit host words into a message
// block, starts the core, and returns the digest one word per fetch.
module hash_host_if #(
  parameter int BUS_W       = 16,
  parameter int MSG_BITS    = 256,
  parameter int DIGEST_BITS = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init,
  input  logic                   load,
  input  logic                   fetch,
  input  logic [BUS_W-1:0]       idata,
  output logic                   ack,
  output logic [BUS_W-1:0]       odata,
  input  logic                   busy,
  input  logic [DIGEST_BITS-1:0] digest,
  output logic                   init_r,
  output logic                   en,
  output logic [MSG_BITS-1:0]    idata_blk,
  output logic                   err
);

  localparam int MW = MSG_BITS / BUS_W;
  localparam int DW = DIGEST_BITS / BUS_W;
  localparam int WW = (MW > 1) ? $clog2(MW) : 1;
  localparam int RW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAP   = 3'd1,
    START = 3'd2,
    EXEC  = 3'd3,
    FETCH = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_load;
  logic            r_fetch;
  logic [WW-1:0]   r_wrCnt;
  logic [RW-1:0]   r_rdCnt;
  logic [BUS_W-1:0] w_dWords [DW];

  // Word 0 of the digest is its most significant BUS_W bits.
  for (genvar g = 0; g < DW; g++) begin : g_dword
    assign w_dWords[g] = digest[DIGEST_BITS-1-g*BUS_W -: BUS_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_r  <= 1'b0;
      r_load  <= 1'b0;
      r_fetch <= 1'b0;
    end else begin
      init_r  <= init;
      r_load  <= load;
      r_fetch <= fetch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    en          = 1'b0;
    if (init_r) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_load)                w_nextState = CAP;
          else if (r_fetch && !busy) w_nextState = FETCH;
        end
        CAP:   w_nextState = (r_wrCnt == WW'(MW - 1)) ? START : IDLE;
        START: begin
          if (!busy) begin
            en          = 1'b1;
            w_nextState = EXEC;
          end
        end
        EXEC:  if (!busy) w_nextState = IDLE;
        FETCH: w_nextState = RESP;
        RESP:  w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Loads arriving while the core is being started or is running are lost, so flag them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack       <= 1'b0;
      odata     <= '0;
      idata_blk <= '0;
      err       <= 1'b0;
      r_wrCnt   <= '0;
      r_rdCnt   <= '0;
    end else begin
      ack <= 1'b0;
      if (init_r) begin
        r_wrCnt <= '0;
        r_rdCnt <= '0;
        err     <= 1'b0;
      end else begin
        case (r_state)
          CAP: begin
            idata_blk <= MSG_BITS'({idata_blk, idata});
            r_wrCnt   <= (r_wrCnt == WW'(MW - 1)) ? '0 : r_wrCnt + WW'(1);
            ack       <= 1'b1;
          end
          FETCH: begin
            odata   <= w_dWords[r_rdCnt];
            r_rdCnt <= (r_rdCnt == RW'(DW - 1)) ? '0 : r_rdCnt + RW'(1);
            ack     <= 1'b1;
          end
          START, EXEC: if (r_load) err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
